// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch front end: start latch, PC and DEPTH-entry {instr, pc} queue.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trigger_i,
    input  logic                         redirect_i,
    input  logic [DATA_WIDTH-1:0]        redirect_pc_i,
    output logic [DATA_WIDTH-1:0]        imem_addr_o,
    input  logic [DATA_WIDTH-1:0]        imem_instr_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DATA_WIDTH-1:0]        instr_o,
    output logic [DATA_WIDTH-1:0]        pc_o,
    output logic [DATA_WIDTH-1:0]        pc_plus_4_o,
    output logic                         running_o,
    output logic                         misalign_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] pc;
    logic                  running;
    logic                  halted;
    logic                  misalign;

    logic                  pop;
    logic                  push;
    logic                  trap_hit;
    logic [DATA_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target   = redirect_pc_i;
    assign trap_hit = redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
    // Low two bits are dropped so a misaligned target lands on the enclosing word.
    assign target   = redirect_pc_i & ~DATA_WIDTH'(3);
    assign trap_hit = 1'b0;
`endif

    assign valid_o     = (count != '0) & ~redirect_i;
    assign pop         = valid_o & ready_i;
    assign push        = running & ~redirect_i & ~halted & ((count < CW'(DEPTH)) | pop);

    assign imem_addr_o = pc;
    assign instr_o     = instr_q[head];
    assign pc_o        = pc_q[head];
    assign pc_plus_4_o = pc_q[head] + DATA_WIDTH'(4);
    assign running_o   = running;
    assign misalign_o  = misalign;
    assign count_o     = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running  <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (trigger_i) running <= 1'b1;
            if (trap_hit) begin
                halted   <= 1'b1;
                misalign <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_i) begin
            pc    <= target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pc + DATA_WIDTH'(4);
                tail <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            // Push and pop together leave occupancy unchanged, including when full.
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[tail] <= imem_instr_i;
            pc_q[tail]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus random bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_4_o;
    logic        running_o;
    logic        misalign_o;
    logic [2:0]  count_o;

    logic [31:0] mem [256];
    assign imem_instr_i = mem[imem_addr_o[9:2]];

    fetch_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .trigger_i(trigger_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
        .pc_plus_4_o(pc_plus_4_o), .running_o(running_o), .misalign_o(misalign_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    logic [31:0] m_pc;
    bit   m_run, m_halt, m_mis, m_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 32'h0; m_run = 0; m_halt = 0; m_mis = 0; m_zero = 1;
    endtask

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (q.size() != 0) && !redirect_i;
        chk("valid", {31'b0, valid_o}, {31'b0, exp_valid});
        chk("count", {29'b0, count_o}, q.size());
        chk("running", {31'b0, running_o}, {31'b0, m_run});
        chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
        chk("imem_addr", imem_addr_o, m_pc);
        if (q.size() != 0) begin
            chk("head_pc", pc_o, q[0].pc);
            chk("head_instr", instr_o, q[0].instr);
            chk("head_pc4", pc_plus_4_o, q[0].pc + 32'd4);
        end else if (m_zero) begin
            chk("empty_pc", pc_o, 32'h0);
            chk("empty_instr", instr_o, 32'h0);
            chk("empty_pc4", pc_plus_4_o, 32'h4);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input logic trig, input logic rdy, input logic redir, input logic [31:0] rpc);
        bit pop, push;
        trigger_i = trig; ready_i = rdy; redirect_i = redir; redirect_pc_i = rpc;
        #1 check_outputs();
        pop  = (q.size() != 0) && !redir && rdy;
        push = m_run && !redir && !m_halt && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (rst) begin
            if (redir) begin
                q.delete();
                m_pc = TRAP ? rpc : (rpc & ~32'h3);
                if (TRAP && rpc[1:0] != 2'b00) begin
                    m_halt = 1; m_mis = 1;
                end
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{mem[m_pc[9:2]], m_pc});
                    m_pc   = m_pc + 32'd4;
                    m_zero = 0;
                end
            end
            if (trig) m_run = 1;
        end
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b0;
        #1;
        chk("arst_running", {31'b0, running_o}, 32'h0);
        chk("arst_count", {29'b0, count_o}, 32'h0);
        chk("arst_valid", {31'b0, valid_o}, 32'h0);
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_pc4", pc_plus_4_o, 32'h4);
        chk("arst_addr", imem_addr_o, 32'h0);
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();

        // Reset held three cycles; trigger must be ignored meanwhile.
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;

        // Start: running after edge N, first head after edge N+1.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("start_running", {31'b0, running_o}, 32'h1);
        chk("start_valid0", {31'b0, valid_o}, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("first_valid", {31'b0, valid_o}, 32'h1);
        chk("first_pc", pc_o, 32'h0);
        chk("first_pc4", pc_plus_4_o, 32'h4);

        // Streaming without bubbles.
        for (int i = 0; i < 10; i++) begin
            chk("stream_valid", {31'b0, valid_o}, 32'h1);
            chk("stream_pc", pc_o, 32'(i * 4));
            chk("stream_instr", instr_o, mem[i]);
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // Backpressure from a fresh start.
        async_reset_check();
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_count", {29'b0, count_o}, 32'd4);
        chk("bp_addr", imem_addr_o, 32'h10);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", pc_o, 32'(i * 4));
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // Redirect on a full queue with ready asserted.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_redir_count", {29'b0, count_o}, 32'd4);
        ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        #1 chk("redir_valid", {31'b0, valid_o}, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        chk("redir_count", {29'b0, count_o}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_head_pc", pc_o, 32'h100);
        chk("redir_head_valid", {31'b0, valid_o}, 32'h1);

        // Random traffic with occasional aligned redirects.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), {22'h0, 8'($urandom_range(0, 255)), 2'b00});
        end

        // Misaligned redirect.
        cycle(1'b0, 1'b1, 1'b1, 32'h102);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        if (TRAP) begin
            chk("mis_flag", {31'b0, misalign_o}, 32'h1);
            chk("mis_valid", {31'b0, valid_o}, 32'h0);
        end else begin
            chk("mis_head_pc", pc_o, 32'h100);
            chk("mis_flag", {31'b0, misalign_o}, 32'h0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0);

        // Async reset mid-stream with three entries queued.
        async_reset_check();
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_arst_count", {29'b0, count_o}, 32'd3);
        async_reset_check();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_arst_running", {31'b0, running_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
